// File: rtl/vga_pkg.sv
// Shared VGA raster constants, phase encoding and phase-length helpers.
// Default timing is 640x480@60 from a 50 MHz clkin.
package vga_pkg;

    localparam int unsigned CNT_W  = 10;
    localparam int unsigned FCNT_W = 16;
    localparam int unsigned PRE_W  = 16;

    localparam int unsigned DEF_CLK_DIV  = 2;
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    localparam int unsigned SYNC_ACTIVE_LOW = 0;
    localparam int unsigned DEF_SYNC_POL    = SYNC_ACTIVE_LOW;

    typedef enum logic [1:0] {
        PH_ACT = 2'd0,
        PH_FP  = 2'd1,
        PH_SYN = 2'd2,
        PH_BP  = 2'd3
    } phase_e;

    function automatic phase_e phase_next(input phase_e ph);
        phase_e nxt;
        case (ph)
            PH_ACT:  nxt = PH_FP;
            PH_FP:   nxt = PH_SYN;
            PH_SYN:  nxt = PH_BP;
            default: nxt = PH_ACT;
        endcase
        return nxt;
    endfunction

    // Terminal count of a phase: the counter value on which the FSM leaves it.
    function automatic logic [CNT_W-1:0] phase_last(input phase_e ph,
                                                    input int unsigned len_act,
                                                    input int unsigned len_fp,
                                                    input int unsigned len_syn,
                                                    input int unsigned len_bp);
        int unsigned len;
        case (ph)
            PH_ACT:  len = len_act;
            PH_FP:   len = len_fp;
            PH_SYN:  len = len_syn;
            default: len = len_bp;
        endcase
        return CNT_W'(len - 1);
    endfunction

endpackage

// File: rtl/vga_timing_ctrl_if.sv
// Raster output bundle between vga_timing_ctrl (master) and the pixel/colour path (slave).
// frame_start/frame_cnt exist only when VGA_FRAME_IRQ_EN is defined.
interface vga_timing_ctrl_if;
    import vga_pkg::*;

    logic              en;
    logic              pix_tick;
    logic              hsync;
    logic              vsync;
    logic              valid;
    logic [CNT_W-1:0]  h_addr;
    logic [CNT_W-1:0]  v_addr;
`ifdef VGA_FRAME_IRQ_EN
    logic              frame_start;
    logic [FCNT_W-1:0] frame_cnt;

    modport master (
        input  en,
        output pix_tick, hsync, vsync, valid, h_addr, v_addr, frame_start, frame_cnt
    );
    modport slave (
        output en,
        input  pix_tick, hsync, vsync, valid, h_addr, v_addr, frame_start, frame_cnt
    );
`else
    modport master (
        input  en,
        output pix_tick, hsync, vsync, valid, h_addr, v_addr
    );
    modport slave (
        output en,
        input  pix_tick, hsync, vsync, valid, h_addr, v_addr
    );
`endif

endinterface

// File: rtl/vga_pix_prescaler.sv
// Divides clkin into a pixel-rate advance strobe (adv_c) and its registered one-cycle pulse.
// Count holds while en is low, so a resumed run continues from the same phase.
module vga_pix_prescaler
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
    input  logic clkin,
    input  logic rst,
    input  logic en,
    output logic adv_c,
    output logic pix_tick
);

    localparam logic [PRE_W-1:0] CNT_LAST = PRE_W'(CLK_DIV - 1);

    logic [PRE_W-1:0] r_cnt;
    logic             r_tick;

    assign adv_c    = en && (r_cnt == CNT_LAST);
    assign pix_tick = r_tick;

    always_ff @(posedge clkin) begin
        if (rst) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= adv_c;
            if (en) begin
                r_cnt <= adv_c ? '0 : r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster sequencer: pixel prescaler plus horizontal/vertical phase FSMs with registered decode.
// Optional frame interrupt outputs are built when VGA_FRAME_IRQ_EN is defined.
module vga_timing_ctrl
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter int unsigned SYNC_POL = DEF_SYNC_POL
) (
    input  logic              clkin,
    input  logic              rst,
    vga_timing_ctrl_if.master bus
);

    localparam logic             SYNC_LVL  = 1'(SYNC_POL);
    localparam logic [CNT_W-1:0] H_RST_CNT = CNT_W'(H_BP - 1);
    localparam logic [CNT_W-1:0] V_RST_CNT = CNT_W'(V_BP - 1);

    logic w_adv_c;
    logic w_pix_tick;

    vga_pix_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_prescaler (
        .clkin    (clkin),
        .rst      (rst),
        .en       (bus.en),
        .adv_c    (w_adv_c),
        .pix_tick (w_pix_tick)
    );

    phase_e           r_hph;
    phase_e           r_vph;
    logic [CNT_W-1:0] r_hcnt;
    logic [CNT_W-1:0] r_vcnt;

    phase_e           w_hph_nxt;
    phase_e           w_vph_nxt;
    logic [CNT_W-1:0] w_hcnt_nxt;
    logic [CNT_W-1:0] w_vcnt_nxt;
    logic             w_h_wrap;
    logic             w_valid_nxt;

    logic             r_hsync;
    logic             r_vsync;
    logic             r_valid;
    logic [CNT_W-1:0] r_h_addr;
    logic [CNT_W-1:0] r_v_addr;

    // Next raster position, applied only on a pixel-advance edge.
    always_comb begin
        w_hph_nxt  = r_hph;
        w_hcnt_nxt = r_hcnt + 1'b1;
        w_vph_nxt  = r_vph;
        w_vcnt_nxt = r_vcnt;
        w_h_wrap   = 1'b0;

        if (r_hcnt == phase_last(r_hph, H_ACTIVE, H_FP, H_SYNC, H_BP)) begin
            w_hph_nxt  = phase_next(r_hph);
            w_hcnt_nxt = '0;
            w_h_wrap   = (r_hph == PH_BP);
        end

        if (w_h_wrap) begin
            if (r_vcnt == phase_last(r_vph, V_ACTIVE, V_FP, V_SYNC, V_BP)) begin
                w_vph_nxt  = phase_next(r_vph);
                w_vcnt_nxt = '0;
            end else begin
                w_vcnt_nxt = r_vcnt + 1'b1;
            end
        end
    end

    assign w_valid_nxt = (w_hph_nxt == PH_ACT) && (w_vph_nxt == PH_ACT);

    // Phase FSMs and decoded outputs share the advance edge so outputs never lag position.
    always_ff @(posedge clkin) begin
        if (rst) begin
            r_hph    <= PH_BP;
            r_hcnt   <= H_RST_CNT;
            r_vph    <= PH_BP;
            r_vcnt   <= V_RST_CNT;
            r_hsync  <= ~SYNC_LVL;
            r_vsync  <= ~SYNC_LVL;
            r_valid  <= 1'b0;
            r_h_addr <= '0;
            r_v_addr <= '0;
        end else if (w_adv_c) begin
            r_hph    <= w_hph_nxt;
            r_hcnt   <= w_hcnt_nxt;
            r_vph    <= w_vph_nxt;
            r_vcnt   <= w_vcnt_nxt;
            r_hsync  <= (w_hph_nxt == PH_SYN) ? SYNC_LVL : ~SYNC_LVL;
            r_vsync  <= (w_vph_nxt == PH_SYN) ? SYNC_LVL : ~SYNC_LVL;
            r_valid  <= w_valid_nxt;
            r_h_addr <= w_valid_nxt ? w_hcnt_nxt : '0;
            r_v_addr <= w_valid_nxt ? w_vcnt_nxt : '0;
        end
    end

    assign bus.pix_tick = w_pix_tick;
    assign bus.hsync    = r_hsync;
    assign bus.vsync    = r_vsync;
    assign bus.valid    = r_valid;
    assign bus.h_addr   = r_h_addr;
    assign bus.v_addr   = r_v_addr;

`ifdef VGA_FRAME_IRQ_EN
    logic              w_enter_origin_c;
    logic              r_frame_start;
    logic [FCNT_W-1:0] r_frame_cnt;

    assign w_enter_origin_c = w_adv_c && w_valid_nxt && (w_hcnt_nxt == '0) && (w_vcnt_nxt == '0);

    // Frame pulse lasts one clkin cycle regardless of en.
    always_ff @(posedge clkin) begin
        if (rst) begin
            r_frame_start <= 1'b0;
            r_frame_cnt   <= '0;
        end else begin
            r_frame_start <= w_enter_origin_c;
            if (w_enter_origin_c) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    assign bus.frame_start = r_frame_start;
    assign bus.frame_cnt   = r_frame_cnt;
`endif

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Self-checking bench for vga_timing_ctrl: two small-raster instances (CLK_DIV 2 and 1, opposite sync
// polarity) checked every cycle against a position-arithmetic model. Honours VGA_FRAME_IRQ_EN.
module tb_vga_timing_ctrl;
    import vga_pkg::*;

    localparam int unsigned HA = 16, HF = 2, HS = 3, HB = 4;
    localparam int unsigned VA = 8,  VF = 1, VS = 2, VB = 3;
    localparam int unsigned HT = HA + HF + HS + HB;
    localparam int unsigned VT = VA + VF + VS + VB;
    localparam int unsigned DIV0 = 2;
    localparam int unsigned DIV1 = 1;
    localparam int unsigned FRAME_CYC0 = HT * VT * DIV0;

    if (HT > 1024 || VT > 1024) begin : g_size_chk
        initial $fatal(1, "FAIL raster_size: HT=%0d VT=%0d exceed 1024", HT, VT);
    end

    logic clkin = 1'b0;
    logic rst   = 1'b1;
    logic en    = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    int unsigned m_div[2] = '{DIV0, DIV1};
    bit          m_pol[2] = '{1'b0, 1'b1};
    int unsigned m_pc[2];
    int unsigned m_h[2];
    int unsigned m_v[2];
    int unsigned m_fc[2];
    bit          m_tick[2];
    bit          m_fs[2];

    always #5 clkin = ~clkin;

    vga_timing_ctrl_if bus0 ();
    vga_timing_ctrl_if bus1 ();
    assign bus0.en = en;
    assign bus1.en = en;

    vga_timing_ctrl #(
        .CLK_DIV(DIV0), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(0)
    ) u_dut0 (
        .clkin (clkin),
        .rst   (rst),
        .bus   (bus0)
    );

    vga_timing_ctrl #(
        .CLK_DIV(DIV1), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1)
    ) u_dut1 (
        .clkin (clkin),
        .rst   (rst),
        .bus   (bus1)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        assert (act === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // Model: a pixel index advanced once per CLK_DIV enabled cycles; reset parks it on the last pixel.
    task automatic model_edge(input bit r, input bit e);
        for (int k = 0; k < 2; k++) begin
            m_tick[k] = 1'b0;
            m_fs[k]   = 1'b0;
            if (r) begin
                m_pc[k] = 0;
                m_h[k]  = HT - 1;
                m_v[k]  = VT - 1;
                m_fc[k] = 0;
            end else if (e) begin
                if (m_pc[k] == m_div[k] - 1) begin
                    m_pc[k]   = 0;
                    m_tick[k] = 1'b1;
                    m_h[k]    = (m_h[k] + 1) % HT;
                    if (m_h[k] == 0) m_v[k] = (m_v[k] + 1) % VT;
                    if (m_h[k] == 0 && m_v[k] == 0) begin
                        m_fs[k] = 1'b1;
                        m_fc[k] = (m_fc[k] + 1) % 65536;
                    end
                end else begin
                    m_pc[k]++;
                end
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            bit          e_valid, e_hs, e_vs;
            int unsigned e_h, e_v;
            logic        a_tick, a_hs, a_vs, a_valid;
            logic [9:0]  a_h, a_v;
            e_valid = (m_h[k] < HA) && (m_v[k] < VA);
            e_hs    = (m_h[k] >= HA + HF && m_h[k] < HA + HF + HS) ? m_pol[k] : !m_pol[k];
            e_vs    = (m_v[k] >= VA + VF && m_v[k] < VA + VF + VS) ? m_pol[k] : !m_pol[k];
            e_h     = e_valid ? m_h[k] : 0;
            e_v     = e_valid ? m_v[k] : 0;
            if (k == 0) begin
                a_tick = bus0.pix_tick; a_hs = bus0.hsync; a_vs = bus0.vsync;
                a_valid = bus0.valid; a_h = bus0.h_addr; a_v = bus0.v_addr;
            end else begin
                a_tick = bus1.pix_tick; a_hs = bus1.hsync; a_vs = bus1.vsync;
                a_valid = bus1.valid; a_h = bus1.h_addr; a_v = bus1.v_addr;
            end
            chk($sformatf("pix_tick[%0d]", k), 32'(a_tick),  32'(m_tick[k]));
            chk($sformatf("hsync[%0d]", k),    32'(a_hs),    32'(e_hs));
            chk($sformatf("vsync[%0d]", k),    32'(a_vs),    32'(e_vs));
            chk($sformatf("valid[%0d]", k),    32'(a_valid), 32'(e_valid));
            chk($sformatf("h_addr[%0d]", k),   32'(a_h),     e_h);
            chk($sformatf("v_addr[%0d]", k),   32'(a_v),     e_v);
`ifdef VGA_FRAME_IRQ_EN
            chk($sformatf("frame_start[%0d]", k),
                32'(k == 0 ? bus0.frame_start : bus1.frame_start), 32'(m_fs[k]));
            chk($sformatf("frame_cnt[%0d]", k),
                32'(k == 0 ? bus0.frame_cnt : bus1.frame_cnt), m_fc[k]);
`endif
        end
    endtask

    task automatic step(input bit r, input bit e);
        rst = r;
        en  = e;
        @(posedge clkin);
        model_edge(r, e);
        #1;
        check_all();
    endtask

    initial begin
        int unsigned hs_low, vs_low, act_ticks, t_idx, first_hs, tick_cnt, h_before;
        int unsigned fs_cnt;
        bit          found;

        // Reset and first pixel
        repeat (3) step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        chk("cycle1_valid", 32'(bus0.valid), 32'd0);
        step(1'b0, 1'b1);
        chk("cycle2_tick",  32'(bus0.pix_tick), 32'd1);
        chk("cycle2_valid", 32'(bus0.valid),    32'd1);
        chk("cycle2_h",     32'(bus0.h_addr),   32'd0);
        chk("cycle2_v",     32'(bus0.v_addr),   32'd0);

        // One full frame on the divide-by-2 instance
        hs_low = 0; vs_low = 0; act_ticks = 0; t_idx = 0; first_hs = 0; fs_cnt = 0;
        for (int i = 0; i < FRAME_CYC0; i++) begin
            step(1'b0, 1'b1);
            if (bus0.pix_tick) t_idx++;
            if (!bus0.hsync) begin
                hs_low++;
                if (first_hs == 0) first_hs = t_idx;
            end
            if (!bus0.vsync) vs_low++;
            if (bus0.valid && bus0.pix_tick) act_ticks++;
`ifdef VGA_FRAME_IRQ_EN
            if (bus0.frame_start) fs_cnt++;
`endif
        end
        chk("hsync_start_tick", first_hs,  HA + HF);
        chk("hsync_low_cyc",    hs_low,    HS * DIV0 * VT);
        chk("vsync_low_cyc",    vs_low,    VS * HT * DIV0);
        chk("active_ticks",     act_ticks, HA * VA);
        chk("frame_wrap_h",     32'(bus0.h_addr), 32'd0);
        chk("frame_wrap_v",     32'(bus0.v_addr), 32'd0);
        chk("frame_wrap_tick",  32'(bus0.pix_tick), 32'd1);
`ifdef VGA_FRAME_IRQ_EN
        chk("frame_start_once", fs_cnt, 1);
`endif

        // Freeze mid-line for 37 cycles
        repeat (21) step(1'b0, 1'b1);
        h_before = m_h[0];
        tick_cnt = 0;
        repeat (37) begin
            step(1'b0, 1'b0);
            tick_cnt += bus0.pix_tick + bus1.pix_tick;
        end
        chk("freeze_ticks", tick_cnt, 0);
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            step(1'b0, 1'b1);
            if (bus0.pix_tick) found = 1'b1;
        end
        chk("resume_tick_seen", 32'(found), 32'd1);
        chk("resume_h_plus1",   32'(bus0.h_addr), h_before + 1);

        // Reset mid-frame at pixel (12,5)
        found = 1'b0;
        for (int i = 0; i < 2 * FRAME_CYC0 && !found; i++) begin
            step(1'b0, 1'b1);
            if (bus0.valid && bus0.h_addr == 10'd12 && bus0.v_addr == 10'd5) found = 1'b1;
        end
        chk("reach_12_5", 32'(found), 32'd1);
        step(1'b1, 1'b1);
        chk("rst_valid", 32'(bus0.valid),    32'd0);
        chk("rst_h",     32'(bus0.h_addr),   32'd0);
        chk("rst_hsync", 32'(bus0.hsync),    32'd1);
        chk("rst_vsync", 32'(bus1.vsync),    32'd0);
        chk("rst_tick",  32'(bus0.pix_tick), 32'd0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        chk("restart_valid", 32'(bus0.valid),  32'd1);
        chk("restart_h",     32'(bus0.h_addr), 32'd0);
        chk("restart_v",     32'(bus0.v_addr), 32'd0);

        // CLK_DIV=1 gives a tick on every enabled cycle
        tick_cnt = 0;
        repeat (50) begin
            step(1'b0, 1'b1);
            tick_cnt += bus1.pix_tick;
        end
        chk("div1_continuous", tick_cnt, 50);

        // Three full frames from reset
        step(1'b1, 1'b0);
        repeat (3 * FRAME_CYC0) step(1'b0, 1'b1);
        chk("three_frames_last_h", 32'(m_h[0]), HT - 1);
`ifdef VGA_FRAME_IRQ_EN
        chk("frame_cnt_3",    32'(bus0.frame_cnt), 32'd3);
        chk("frame_cnt_div1", 32'(bus1.frame_cnt), 32'd6);
`endif

        // Randomized en / occasional reset
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 499) == 0), ($urandom_range(0, 9) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
